// File: rtl/rx_bit_sampler.sv
// UART RX bit timing: input synchroniser, edge/bit counters, and a 3-sample majority vote
// that produces sampled_bit for the deserializer.
module rx_bit_sampler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 11
) (
  input  logic       deserializer_clk,
  input  logic       deserializer_rst,
  input  logic       RX_IN,
  input  logic [4:0] Prescale,
  input  logic       cnt_en,
  input  logic       dat_samp_en,
  output logic [4:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_done,
  output logic       frame_done
);

  localparam logic [4:0] MinPrescale = 5'd8;
  localparam logic [3:0] LastBit     = 4'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [4:0] prescale_q, prescale_d;
  logic       cnt_en_q;
  logic [4:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] vote_q, vote_d;
  logic [1:0] vote_cnt_q, vote_cnt_d;
  logic       sampled_q, sampled_d;

  logic [4:0] last_edge, mid;
  logic       edge_wrap, capture_p, majority;
  logic       at_first, at_mid, at_last, at_decide;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign last_edge = prescale_q - 5'd1;
  assign mid       = {1'b0, prescale_q[4:1]};
  assign edge_wrap = (edge_q == last_edge);
  assign at_first  = (edge_q == mid - 5'd1);
  assign at_mid    = (edge_q == mid);
  assign at_last   = (edge_q == mid + 5'd1);
  assign at_decide = (edge_q == mid + 5'd2);
  assign majority  = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

  // Decoded from the registered counters so it lines up with bit_cnt/edge_cnt on the bus.
  assign frame_done = edge_wrap && (bit_q == LastBit);

  // P only changes at frame boundaries so a frame never sees two different bit lengths.
  assign capture_p = (cnt_en && !cnt_en_q) || frame_done;

  always_comb begin
    prescale_d = prescale_q;
    if (capture_p) begin
      prescale_d = (Prescale < MinPrescale) ? MinPrescale : Prescale;
    end
  end

  always_comb begin
    edge_d = edge_q + 5'd1;
    bit_d  = bit_q;
    if (!cnt_en) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_wrap) begin
      edge_d = '0;
      bit_d  = frame_done ? 4'd0 : bit_q + 4'd1;
    end
  end

  // vote_cnt tracks how many consecutive mid-bit samples were taken with sampling enabled;
  // any gap in dat_samp_en throws the partial vote away.
  always_comb begin
    vote_d      = vote_q;
    vote_cnt_d  = vote_cnt_q;
    sampled_d   = sampled_q;
    sample_done = 1'b0;
    if (!dat_samp_en) begin
      vote_cnt_d = '0;
    end else if (at_first) begin
      vote_d     = {vote_q[1:0], rx_s};
      vote_cnt_d = 2'd1;
    end else if (at_mid || at_last) begin
      vote_d     = {vote_q[1:0], rx_s};
      vote_cnt_d = (vote_cnt_q == 2'd0) ? 2'd0 : vote_cnt_q + 2'd1;
    end else if (at_decide) begin
      if (vote_cnt_q == 2'd3) begin
        sampled_d   = majority;
        sample_done = 1'b1;
      end
      vote_cnt_d = '0;
    end
  end

  always_ff @(posedge deserializer_clk or negedge deserializer_rst) begin
    if (!deserializer_rst) begin
      sync_q     <= '1;
      prescale_q <= MinPrescale;
      cnt_en_q   <= 1'b0;
      edge_q     <= '0;
      bit_q      <= '0;
      vote_q     <= 3'b111;
      vote_cnt_q <= '0;
      sampled_q  <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      prescale_q <= prescale_d;
      cnt_en_q   <= cnt_en;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      vote_q     <= vote_d;
      vote_cnt_q <= vote_cnt_d;
      sampled_q  <= sampled_d;
    end
  end

  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign sampled_bit = sampled_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Scoreboard bench for rx_bit_sampler: a frame-position model predicts counters, votes and
// frame boundaries from the stimulus plan; a monitor compares the DUT each cycle.
module tb_rx_bit_sampler;

  localparam int S  = 2;
  localparam int FB = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       cnt_en = 1'b0;
  logic       dse = 1'b0;
  logic [4:0] prescale = 5'd8;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit, sample_done, frame_done;

  always #5 clk = ~clk;

  rx_bit_sampler #(.SYNC_STAGES(S), .FRAME_BITS(FB)) dut (
    .deserializer_clk(clk),
    .deserializer_rst(rst_n),
    .RX_IN           (rx_in),
    .Prescale        (prescale),
    .cnt_en          (cnt_en),
    .dat_samp_en     (dse),
    .edge_cnt        (edge_cnt),
    .bit_cnt         (bit_cnt),
    .sampled_bit     (sampled_bit),
    .sample_done     (sample_done),
    .frame_done      (frame_done)
  );

  typedef struct {bit ce; bit ds; int ps; bit rx;} stim_t;
  typedef struct {int cyc; int ecnt; int bcnt; bit sb;} cyc_exp_t;
  typedef struct {int cyc; bit val;} samp_exp_t;

  stim_t     plan[$];
  cyc_exp_t  cyc_q[$];
  samp_exp_t samp_q[$];
  int        frame_q[$];
  int        checks = 0;
  int        errors = 0;
  bit        mon_on = 1'b0;
  bit        cont = 1'b0;
  int        p_carry = 8;

  task automatic chk(string name, int act, int exp, int cyc);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int eff_p(int p);
    return (p < 8) ? 8 : p;
  endfunction

  task automatic idle(int n);
    stim_t s;
    s.ce = 1'b0; s.ds = 1'b0; s.ps = 8; s.rx = 1'b1;
    for (int i = 0; i < n; i++) plan.push_back(s);
    cont = 1'b0;
  endtask

  // One frame of line activity; glitches invert rx_s, nods_bit disables sampling for a whole
  // slot, gap_bit drops sampling at mid-bit only, drop_bit stops counting at that slot.
  task automatic frame(int ps_a, int ps_b, logic [7:0] data, int gl_bit, int gl_e0, int gl_len,
                       int nods_bit, int gap_bit, int drop_bit);
    logic [10:0] bits;
    int          p;
    stim_t       s;
    bits = {1'b1, ^data, data, 1'b0};
    p = cont ? p_carry : eff_p(ps_a);
    for (int b = 0; b < FB; b++) begin
      for (int e = 0; e < p; e++) begin
        s.ce = 1'b1;
        s.ps = (b < 5) ? ps_a : ps_b;
        s.rx = bits[b];
        if (b == gl_bit && e >= gl_e0 && e < gl_e0 + gl_len) s.rx = ~bits[b];
        s.ds = !(b == nods_bit) && !(b == gap_bit && e == p / 2);
        if (b == drop_bit && e == 0) begin
          s.ce = 1'b0;
          plan.push_back(s);
          cont = 1'b0;
          return;
        end
        plan.push_back(s);
      end
    end
    cont = 1'b1;
    p_carry = eff_p(ps_b);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : monitor
    cyc_exp_t  cx;
    samp_exp_t sx;
    bit        pend;
    bit        pend_val;
    bit        exp_sd, exp_fd;
    pend = 1'b0;
    pend_val = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on && cyc_q.size() > 0) begin
        cx = cyc_q.pop_front();
        if (pend) begin
          chk("sample_value", int'(sampled_bit), int'(pend_val), cx.cyc);
          pend = 1'b0;
        end
        chk("edge_cnt", int'(edge_cnt), cx.ecnt, cx.cyc);
        chk("bit_cnt", int'(bit_cnt), cx.bcnt, cx.cyc);
        chk("sampled_bit", int'(sampled_bit), int'(cx.sb), cx.cyc);
        exp_sd = samp_q.size() > 0 && samp_q[0].cyc == cx.cyc;
        if (sample_done || exp_sd) begin
          chk("sample_done", int'(sample_done), int'(exp_sd), cx.cyc);
          if (exp_sd) begin
            sx = samp_q.pop_front();
            if (sample_done) begin
              pend = 1'b1;
              pend_val = sx.val;
            end
          end
        end
        exp_fd = frame_q.size() > 0 && frame_q[0] == cx.cyc;
        if (frame_done || exp_fd) begin
          chk("frame_done", int'(frame_done), int'(exp_fd), cx.cyc);
          if (exp_fd) void'(frame_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    int        fpos, p_cur, p_next, e_now, b_now, m;
    bit        ce_prev, sb_cur, fd, sd, v;
    int        hist_e[$];
    bit        found;
    int        ps_a, ps_b, nods, gap, drop;
    samp_exp_t se;

    // Directed frames first, then randomised ones.
    idle(4);
    frame(8, 8, 8'hA5, -1, 0, 0, -1, -1, -1);
    frame(8, 8, 8'hA5, -1, 0, 0, -1, -1, -1);
    frame(8, 8, 8'hA5, -1, 0, 0, -1, -1, 4);
    idle(3);
    frame(4, 16, 8'h5A, -1, 0, 0, -1, -1, -1);
    frame(16, 16, 8'hFF, 2, 8, 1, -1, -1, -1);
    frame(16, 16, 8'hFF, 3, 7, 2, -1, -1, -1);
    frame(16, 16, 8'h3C, -1, 0, 0, 4, 6, -1);
    idle(5);
    repeat (24) begin
      ps_a = $urandom_range(0, 31);
      ps_b = ($urandom % 3 == 0) ? $urandom_range(0, 31) : ps_a;
      nods = ($urandom % 5 == 0) ? $urandom_range(0, 10) : -1;
      gap  = ($urandom % 5 == 0) ? $urandom_range(0, 10) : -1;
      drop = ($urandom % 6 == 0) ? $urandom_range(1, 10) : -1;
      frame(ps_a, ps_b, 8'($urandom), $urandom_range(0, 10), $urandom_range(2, 18),
            $urandom_range(0, 3), nods, gap, drop);
      if ($urandom % 4 == 0) idle($urandom_range(1, 4));
    end
    idle(6);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_edge_cnt", int'(edge_cnt), 0, -1);
    chk("reset_bit_cnt", int'(bit_cnt), 0, -1);
    chk("reset_sampled_bit", int'(sampled_bit), 1, -1);
    chk("reset_sample_done", int'(sample_done), 0, -1);
    chk("reset_frame_done", int'(frame_done), 0, -1);
    @(negedge clk);
    rst_n = 1'b1;

    fpos = 0; p_cur = 8; ce_prev = 1'b0; sb_cur = 1'b1;
    mon_on = 1'b1;
    for (int k = 0; k < plan.size(); k++) begin
      @(negedge clk);
      cnt_en   = plan[k].ce;
      dse      = plan[k].ds;
      prescale = 5'(plan[k].ps);
      rx_in    = (k + S < plan.size()) ? plan[k + S].rx : 1'b1;

      e_now = fpos % p_cur;
      b_now = fpos / p_cur;
      fd    = (fpos == FB * p_cur - 1);
      hist_e.push_back(e_now);
      m  = p_cur / 2;
      sd = 1'b0;
      if (k >= 3 && e_now == m + 2) begin
        sd = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (!plan[k - i].ds || hist_e[k - i] != m + 2 - i) sd = 1'b0;
        end
      end
      cyc_q.push_back('{cyc: k, ecnt: e_now, bcnt: b_now, sb: sb_cur});
      if (fd) frame_q.push_back(k);
      if (sd) begin
        v = (int'(plan[k - 3].rx) + int'(plan[k - 2].rx) + int'(plan[k - 1].rx)) >= 2;
        se.cyc = k;
        se.val = v;
        samp_q.push_back(se);
        sb_cur = v;
      end
      p_next = ((plan[k].ce && !ce_prev) || fd) ? eff_p(plan[k].ps) : p_cur;
      fpos   = (!plan[k].ce || fd) ? 0 : fpos + 1;
      ce_prev = plan[k].ce;
      p_cur   = p_next;
    end
    repeat (2) @(negedge clk);
    #2;
    mon_on = 1'b0;
    chk("samples_left", samp_q.size(), 0, -1);
    chk("frames_left", frame_q.size(), 0, -1);

    // Asynchronous reset in the middle of a frame of zeros.
    cnt_en = 1'b0; dse = 1'b1; rx_in = 1'b0; prescale = 5'd8;
    repeat (3) @(negedge clk);
    cnt_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (edge_cnt == 5'd5 && bit_cnt == 4'd3) found = 1'b1;
    end
    chk("reach_bit3_edge5", int'(found), 1, -1);
    chk("pre_reset_sampled_bit", int'(sampled_bit), 0, -1);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_edge_cnt", int'(edge_cnt), 0, -1);
    chk("midframe_rst_bit_cnt", int'(bit_cnt), 0, -1);
    chk("midframe_rst_sampled_bit", int'(sampled_bit), 1, -1);
    chk("midframe_rst_sample_done", int'(sample_done), 0, -1);
    chk("midframe_rst_frame_done", int'(frame_done), 0, -1);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("in_rst_edge_cnt", int'(edge_cnt), 0, -1);
      chk("in_rst_sample_done", int'(sample_done), 0, -1);
    end
    cnt_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
